pb_bus_sequencer: RTL and testbench
===================================

PB_BUS_SEQUENCER -- requirements
Module: pb_bus_sequencer

Interface
REQ-001 SETUP_CYCLES, default 3: clocks that board, address and data are stable before the strobe; legal range 1-255.
REQ-002 STROBE_CYCLES, default 6: clocks that RdP/WrP are asserted; legal range 1-255.
REQ-003 HOLD_CYCLES, default 3: clocks that board, address and data are held after the strobe; legal range 1-255.
REQ-004 clock  in  1  system clock, 27 MHz; all logic rising-edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  2  per-requester transaction request; bit i belongs to requester i.
REQ-007 req_ready  out  2  per-requester accept; transfer occurs when valid[i] and ready[i] are both 1.
REQ-008 req_write  in  2  1 = write cycle, 0 = read cycle.
REQ-009 req_board  in  8  board select, 4 bits per requester; requester i uses bits [4i+3:4i].
REQ-010 req_addr  in  6  register address, 3 bits per requester.
REQ-011 req_wdata  in  16  write data, 8 bits per requester.
REQ-012 rsp_valid  out  2  one-cycle completion pulse to the owning requester.
REQ-013 rsp_rdata  out  8  read data; valid while any rsp_valid bit is 1.
REQ-014 BOARD_X  out  4  board select to the lamp bus.
REQ-015 AddessPortPin  out  3  address to the lamp bus.
REQ-016 RdP, WrP  out  1 each  bus strobes; active-low; idle high.
REQ-017 Data_Out_Port  out  8  write data toward the tristate buffer.
REQ-018 Data_In_Port  in  8  pad read-back.
REQ-019 data_dir  out  1  1 = drive the pads, 0 = high-Z.
REQ-020 busy  out  1  high in every state except IDLE.

Function
REQ-021 FSM states: IDLE, SETUP, STROBE, HOLD, DONE.
REQ-022 In IDLE, req_ready SHALL be combinational and at most one-hot: the single valid requester; if both are valid, the requester not granted last.
REQ-023 On accept the block SHALL latch write, board, addr and wdata, record the owner and last_grant, and enter SETUP.
REQ-024 On the accept edge, BOARD_X and AddessPortPin SHALL load the request; Data_Out_Port loads wdata; data_dir = write.
REQ-025 SETUP lasts SETUP_CYCLES clocks, STROBE lasts STROBE_CYCLES clocks and HOLD lasts HOLD_CYCLES clocks, timed by one 8-bit down-counter reloaded at each transition.
REQ-026 During STROBE, RdP = 0 for reads and WrP = 0 for writes; the other strobe stays 1; neither strobe is low outside STROBE.
REQ-027 Read data: Data_In_Port SHALL be registered on the last STROBE clock.
REQ-028 DONE lasts one clock: rsp_valid[owner] = 1, rsp_rdata = captured data (8'h00 for writes), data_dir = 0, next state IDLE.
REQ-029 Latency from the accept edge to rsp_valid high SHALL be SETUP+STROBE+HOLD+1 clocks (13 at defaults).
REQ-030 BOARD_X, AddessPortPin and Data_Out_Port SHALL keep their last values in IDLE and DONE; data_dir = 0 there.
REQ-031 With both requesters continuously valid, grants SHALL alternate; a lone requester is re-granted in the IDLE after its DONE (one idle clock between transactions).
REQ-032 Dropping valid before ready is legal and SHALL be ignored; request fields are sampled only on the accept edge.
REQ-033 An out-of-range parameter (0 or >255) SHALL stop elaboration with an error.

Reset
REQ-034 While reset is high, asynchronously:
- state = IDLE; last_grant = 1 (requester 0 wins the first tie)
- RdP = WrP = 1
- data_dir = 0
- BOARD_X, AddessPortPin, Data_Out_Port, rsp_rdata = 0
- rsp_valid, req_ready = 0; busy = 0
REQ-035 Reset mid-transaction SHALL abort it with no rsp_valid; the first clock after release is IDLE.

Structure
REQ-036 Package pb_bus_pkg SHALL hold the FSM state enum, the default timing constants and the requester count (2).
REQ-037 The tie-break logic SHALL be a sub-module, pb_rr_arbiter (2-way round-robin, last_grant input, one-hot grant output).

Verification
REQ-038 Write, req0, board 4'h2, addr 3'h5, data 8'hA5, defaults -> WrP low exactly 6 clocks; data_dir high 12 clocks; buses stable throughout; rsp_valid = 2'b01 at accept+13.
REQ-039 Read, req1, Data_In_Port = 8'h3C during STROBE -> RdP low 6 clocks; data_dir 0 throughout; rsp_valid = 2'b10 with rsp_rdata = 8'h3C.
REQ-040 Both valid on the first clock after reset -> req0 served first, req1 accepted the clock after req0's DONE.
REQ-041 Both held valid for 4 transactions -> grant order 0,1,0,1; exactly one rsp_valid per transaction.
REQ-042 Reset asserted on the 3rd STROBE clock of a write -> WrP = 1 and data_dir = 0 with no clock edge; no rsp_valid; a following read completes normally.

Source files
------------

// File: rtl/pb_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pb_bus_pkg
// Purpose  : Shared types and timing defaults for the lamp-bus sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package pb_bus_pkg;

  localparam int c_N_REQ              = 2;
  localparam int c_DEF_SETUP_CYCLES   = 3;
  localparam int c_DEF_STROBE_CYCLES  = 6;
  localparam int c_DEF_HOLD_CYCLES    = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } pb_state_e;

endpackage
`default_nettype wire

// File: rtl/pb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pb_rr_arbiter
// Purpose  : Two-way round-robin tie-break producing a one-hot grant.
// Revision : 1.0 - initial release
// ============================================================================
module pb_rr_arbiter
  import pb_bus_pkg::*;
(
  input  logic [c_N_REQ-1:0] req_i,
  input  logic               last_grant_i,
  output logic [c_N_REQ-1:0] grant_o
);

  // On a tie the requester that did not win last time gets the bus.
  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/pb_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pb_bus_sequencer
// Purpose  : Two-requester sequencer driving setup/strobe/hold lamp-bus cycles.
// Revision : 1.0 - initial release
// ============================================================================
module pb_bus_sequencer
  import pb_bus_pkg::*;
#(
  parameter int SETUP_CYCLES  = c_DEF_SETUP_CYCLES,
  parameter int STROBE_CYCLES = c_DEF_STROBE_CYCLES,
  parameter int HOLD_CYCLES   = c_DEF_HOLD_CYCLES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_write,
  input  logic [7:0]  req_board,
  input  logic [5:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic [1:0]  rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic [3:0]  BOARD_X,
  output logic [2:0]  AddessPortPin,
  output logic        RdP,
  output logic        WrP,
  output logic [7:0]  Data_Out_Port,
  input  logic [7:0]  Data_In_Port,
  output logic        data_dir,
  output logic        busy
);

  if (SETUP_CYCLES < 1 || SETUP_CYCLES > 255) begin : g_bad_setup
    $error("SETUP_CYCLES must be within 1..255");
  end
  if (STROBE_CYCLES < 1 || STROBE_CYCLES > 255) begin : g_bad_strobe
    $error("STROBE_CYCLES must be within 1..255");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("HOLD_CYCLES must be within 1..255");
  end

  localparam logic [7:0] c_SETUP_LOAD  = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] c_STROBE_LOAD = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] c_HOLD_LOAD   = 8'(HOLD_CYCLES - 1);

  pb_state_e   state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic        owner_q, owner_d;
  logic        last_grant_q, last_grant_d;
  logic [3:0]  board_q, board_d;
  logic [2:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rdp_q, rdp_d;
  logic        wrp_q, wrp_d;
  logic        dir_q, dir_d;

  logic [1:0]  w_grant;
  logic        w_accept;
  logic        w_sel;

  pb_rr_arbiter u_arb (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (w_grant)
  );

  // Ready is offered only while idle; reset forces it low without a clock.
  assign req_ready = (state_q == ST_IDLE && !reset) ? w_grant : 2'b00;
  assign w_accept  = |(req_valid & req_ready);
  assign w_sel     = req_ready[1];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    board_d      = board_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          state_d      = ST_SETUP;
          cnt_d        = c_SETUP_LOAD;
          write_d      = req_write[w_sel];
          owner_d      = w_sel;
          last_grant_d = w_sel;
          board_d      = w_sel ? req_board[7:4]  : req_board[3:0];
          addr_d       = w_sel ? req_addr[5:3]   : req_addr[2:0];
          wdata_d      = w_sel ? req_wdata[15:8] : req_wdata[7:0];
          rdata_d      = 8'h00;
        end
      end
      ST_SETUP: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_STROBE;
          cnt_d   = c_STROBE_LOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_STROBE: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_HOLD;
          cnt_d   = c_HOLD_LOAD;
          if (!write_q) rdata_d = Data_In_Port;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == 8'd0) state_d = ST_DONE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Strobes and direction are registered from the next state so the pads
    // switch cleanly on the state-transition edge.
    rdp_d = !(state_d == ST_STROBE && !write_d);
    wrp_d = !(state_d == ST_STROBE && write_d);
    dir_d = write_d && (state_d inside {ST_SETUP, ST_STROBE, ST_HOLD});
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 8'd0;
      write_q      <= 1'b0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      board_q      <= 4'd0;
      addr_q       <= 3'd0;
      wdata_q      <= 8'd0;
      rdata_q      <= 8'd0;
      rdp_q        <= 1'b1;
      wrp_q        <= 1'b1;
      dir_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      board_q      <= board_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      rdp_q        <= rdp_d;
      wrp_q        <= wrp_d;
      dir_q        <= dir_d;
    end
  end

  assign rsp_valid     = (state_q == ST_DONE) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_rdata     = rdata_q;
  assign busy          = (state_q != ST_IDLE);
  assign BOARD_X       = board_q;
  assign AddessPortPin = addr_q;
  assign Data_Out_Port = wdata_q;
  assign RdP           = rdp_q;
  assign WrP           = wrp_q;
  assign data_dir      = dir_q;

endmodule
`default_nettype wire

// File: tb/tb_pb_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pb_bus_sequencer
// Purpose  : Self-checking bench for pb_bus_sequencer at default timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pb_bus_sequencer;

  localparam int c_S = 3;
  localparam int c_P = 6;
  localparam int c_H = 3;
  localparam int c_T = c_S + c_P + c_H + 1;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_write;
  logic [7:0]  req_board;
  logic [5:0]  req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [3:0]  BOARD_X;
  logic [2:0]  AddessPortPin;
  logic        RdP;
  logic        WrP;
  logic [7:0]  Data_Out_Port;
  logic [7:0]  Data_In_Port;
  logic        data_dir;
  logic        busy;

  logic        din_mode;
  logic [7:0]  din_fixed;

  pb_bus_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_board     (req_board),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .BOARD_X       (BOARD_X),
    .AddessPortPin (AddessPortPin),
    .RdP           (RdP),
    .WrP           (WrP),
    .Data_Out_Port (Data_Out_Port),
    .Data_In_Port  (Data_In_Port),
    .data_dir      (data_dir),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  always begin
    @(posedge clock);
    #2;
    Data_In_Port = din_mode ? 8'($urandom) : din_fixed;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Transaction-level model: phase 0 is idle, 1..c_T counts clocks since accept.
  int         m_phase = 0;
  logic       m_last;
  logic       m_owner;
  logic       m_write;
  logic [3:0] m_board;
  logic [2:0] m_addr;
  logic [7:0] m_wdata;
  logic [7:0] m_rdata;
  logic [1:0] m_g;
  logic       m_strobe;
  logic       m_active;

  function automatic logic [1:0] m_grant(input logic [1:0] v, input logic last);
    if (v == 2'b11) return last ? 2'b01 : 2'b10;
    return v;
  endfunction

  assign m_g      = m_grant(req_valid, m_last);
  assign m_strobe = (m_phase > c_S) && (m_phase <= c_S + c_P);
  assign m_active = (m_phase >= 1) && (m_phase <= c_S + c_P + c_H);

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset) begin
      m_phase <= 0;
      m_last  <= 1'b1;
      m_board <= 4'd0;
      m_addr  <= 3'd0;
      m_wdata <= 8'd0;
      m_rdata <= 8'd0;
    end else if (m_phase == 0) begin
      if (m_g != 2'b00) begin
        m_phase <= 1;
        m_owner <= m_g[1];
        m_last  <= m_g[1];
        m_write <= req_write[m_g[1]];
        m_board <= m_g[1] ? req_board[7:4]  : req_board[3:0];
        m_addr  <= m_g[1] ? req_addr[5:3]   : req_addr[2:0];
        m_wdata <= m_g[1] ? req_wdata[15:8] : req_wdata[7:0];
        m_rdata <= 8'h00;
      end
    end else if (m_phase == c_T) begin
      m_phase <= 0;
    end else begin
      if (m_phase == c_S + c_P && !m_write) m_rdata <= Data_In_Port;
      m_phase <= m_phase + 1;
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      check("rst_req_ready", 32'(req_ready), 32'h0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_RdP", 32'(RdP), 32'h1);
      check("rst_WrP", 32'(WrP), 32'h1);
      check("rst_data_dir", 32'(data_dir), 32'h0);
      check("rst_BOARD_X", 32'(BOARD_X), 32'h0);
      check("rst_addr", 32'(AddessPortPin), 32'h0);
      check("rst_dout", 32'(Data_Out_Port), 32'h0);
      check("rst_rdata", 32'(rsp_rdata), 32'h0);
    end else begin
      check("req_ready", 32'(req_ready), 32'((m_phase == 0) ? m_g : 2'b00));
      check("busy", 32'(busy), 32'(m_phase != 0));
      check("RdP", 32'(RdP), 32'(!(m_strobe && !m_write)));
      check("WrP", 32'(WrP), 32'(!(m_strobe && m_write)));
      check("data_dir", 32'(data_dir), 32'(m_active && m_write));
      check("BOARD_X", 32'(BOARD_X), 32'(m_board));
      check("addr", 32'(AddessPortPin), 32'(m_addr));
      check("dout", 32'(Data_Out_Port), 32'(m_wdata));
      check("rsp_valid", 32'(rsp_valid),
            32'((m_phase == c_T) ? (m_owner ? 2'b10 : 2'b01) : 2'b00));
      if (m_phase == c_T) check("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
    end
  end

  // Observation log used by the directed, hand-computed checks.
  int         acc_n = 0;
  int         rsp_n = 0;
  int         wrp_low = 0;
  int         rdp_low = 0;
  int         dd_high = 0;
  logic [7:0] last_rdata;
  logic       acc_q[$];
  int         acc_cyc_q[$];
  int         rsp_cyc_q[$];
  logic [1:0] rsp_v_q[$];

  always @(negedge clock) begin
    if (!reset) begin
      if (|(req_valid & req_ready)) begin
        acc_q.push_back(req_ready[1]);
        acc_cyc_q.push_back(cyc);
        acc_n <= acc_n + 1;
      end
      if (|rsp_valid) begin
        rsp_cyc_q.push_back(cyc);
        rsp_v_q.push_back(rsp_valid);
        last_rdata <= rsp_rdata;
        rsp_n <= rsp_n + 1;
      end
      wrp_low <= wrp_low + (WrP ? 0 : 1);
      rdp_low <= rdp_low + (RdP ? 0 : 1);
      dd_high <= dd_high + (data_dir ? 1 : 0);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_req(input int i, input logic w, input logic [3:0] b,
                           input logic [2:0] a, input logic [7:0] d);
    int n0;
    int k;
    n0 = acc_n;
    req_write[i]        = w;
    req_board[4*i +: 4] = b;
    req_addr[3*i +: 3]  = a;
    req_wdata[8*i +: 8] = d;
    req_valid[i]        = 1'b1;
    k = 0;
    while (acc_n == n0 && k < 40) begin
      tick();
      k++;
    end
    req_valid[i] = 1'b0;
    check("accept_seen", 32'(acc_n - n0), 32'd1);
  endtask

  task automatic wait_rsp(input int i, input bit poke);
    int r0;
    int k;
    r0 = rsp_n;
    k = 0;
    while (rsp_n == r0 && k < 40) begin
      tick();
      k++;
      if (poke && k == 2) req_valid[1-i] = 1'b1;
      if (poke && k == 5) req_valid[1-i] = 1'b0;
    end
    check("rsp_seen", 32'(rsp_n - r0), 32'd1);
  endtask

  int n0, r0, wrp0, rdp0, dd0, k;
  logic [3:0] exp_order;
  logic [1:0] exp_rsp [4];

  initial begin
    reset     = 1'b1;
    req_valid = 2'b00;
    req_write = 2'b00;
    req_board = 8'h00;
    req_addr  = 6'h00;
    req_wdata = 16'h0000;
    din_mode  = 1'b0;
    din_fixed = 8'h00;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Write from requester 0
    wrp0 = wrp_low; rdp0 = rdp_low; dd0 = dd_high;
    start_req(0, 1'b1, 4'h2, 3'h5, 8'hA5);
    wait_rsp(0, 1'b0);
    check("wr_WrP_low_clks", 32'(wrp_low - wrp0), 32'd6);
    check("wr_RdP_low_clks", 32'(rdp_low - rdp0), 32'd0);
    check("wr_dir_high_clks", 32'(dd_high - dd0), 32'd12);
    check("wr_latency", 32'(rsp_cyc_q[$] - acc_cyc_q[$]), 32'd13);
    check("wr_rsp_valid", 32'(rsp_v_q[$]), 32'h1);
    check("wr_rsp_rdata", 32'(last_rdata), 32'h00);
    check("wr_BOARD_X_held", 32'(BOARD_X), 32'h2);
    check("wr_addr_held", 32'(AddessPortPin), 32'h5);
    check("wr_dout_held", 32'(Data_Out_Port), 32'hA5);

    // Read from requester 1, with requester 0 briefly valid while busy
    din_fixed = 8'h3C;
    wrp0 = wrp_low; rdp0 = rdp_low; dd0 = dd_high; n0 = acc_n;
    start_req(1, 1'b0, 4'h7, 3'h3, 8'h11);
    wait_rsp(1, 1'b1);
    repeat (3) tick();
    check("rd_RdP_low_clks", 32'(rdp_low - rdp0), 32'd6);
    check("rd_WrP_low_clks", 32'(wrp_low - wrp0), 32'd0);
    check("rd_dir_high_clks", 32'(dd_high - dd0), 32'd0);
    check("rd_latency", 32'(rsp_cyc_q[$] - acc_cyc_q[$]), 32'd13);
    check("rd_rsp_valid", 32'(rsp_v_q[$]), 32'h2);
    check("rd_rsp_rdata", 32'(last_rdata), 32'h3C);
    check("rd_dropped_valid_ignored", 32'(acc_n - n0), 32'd1);

    // Both requesters valid from the first clock after reset, held for 4 grants
    reset = 1'b1;
    tick();
    tick();
    din_mode  = 1'b1;
    req_write = 2'b01;
    req_board = 8'h91;
    req_addr  = 6'o61;
    req_wdata = 16'h7711;
    req_valid = 2'b11;
    n0 = acc_n; r0 = rsp_n;
    reset = 1'b0;
    k = 0;
    while (acc_n - n0 < 4 && k < 100) begin
      tick();
      k++;
    end
    req_valid = 2'b00;
    k = 0;
    while (rsp_n - r0 < 4 && k < 40) begin
      tick();
      k++;
    end
    repeat (5) tick();
    check("rr_accepts", 32'(acc_n - n0), 32'd4);
    check("rr_responses", 32'(rsp_n - r0), 32'd4);
    exp_order  = 4'b1010;
    exp_rsp[0] = 2'b01; exp_rsp[1] = 2'b10; exp_rsp[2] = 2'b01; exp_rsp[3] = 2'b10;
    for (int j = 0; j < 4; j++) begin
      check($sformatf("rr_grant_%0d", j), 32'(acc_q[n0+j]), 32'(exp_order[j]));
      check($sformatf("rr_rsp_%0d", j), 32'(rsp_v_q[r0+j]), 32'(exp_rsp[j]));
    end
    check("rr_req1_after_done", 32'(acc_cyc_q[n0+1] - rsp_cyc_q[r0]), 32'd1);
    din_mode = 1'b0;

    // Reset on the 3rd strobe clock of a write aborts it immediately
    r0 = rsp_n;
    start_req(0, 1'b1, 4'h3, 3'h2, 8'h5A);
    repeat (5) tick();
    #1;
    check("abort_WrP_low_before", 32'(WrP), 32'h0);
    reset = 1'b1;
    #1;
    check("abort_WrP_async", 32'(WrP), 32'h1);
    check("abort_dir_async", 32'(data_dir), 32'h0);
    check("abort_busy_async", 32'(busy), 32'h0);
    check("abort_rsp_async", 32'(rsp_valid), 32'h0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("abort_idle_after_release", 32'(busy), 32'h0);
    repeat (15) tick();
    check("abort_no_rsp", 32'(rsp_n - r0), 32'd0);

    din_fixed = 8'hC3;
    start_req(1, 1'b0, 4'hE, 3'h6, 8'h00);
    wait_rsp(1, 1'b0);
    check("post_abort_rsp_valid", 32'(rsp_v_q[$]), 32'h2);
    check("post_abort_rdata", 32'(last_rdata), 32'hC3);
    check("post_abort_latency", 32'(rsp_cyc_q[$] - acc_cyc_q[$]), 32'd13);

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
